// File: rtl/alu_iter_if.sv
// alu_iter_if: request/result handshake bundle for alu_iter
// Ports: in_valid/in_ready/alu_cntrl/src1/src2 request, out_valid/out_ready/result/illegal response, flush abort.
// master drives requests and consumes results; slave is the ALU.
interface alu_iter_if #(
  parameter int XLEN = 32
);
  logic in_valid;
  logic in_ready;
  logic [5:0] alu_cntrl;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] result;
  logic illegal;
  modport master (
    output in_valid, alu_cntrl, src1, src2, flush, out_ready,
    input in_ready, out_valid, result, illegal
  );
  modport slave (
    input in_valid, alu_cntrl, src1, src2, flush, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/alu_iter.sv
// alu_iter: integer ALU with single-cycle ops and optional iterative multiply/divide
// Ports: clk; rst_n (async active-low); bus (alu_iter_if.slave) carrying the in_valid/in_ready request
// with alu_cntrl/src1/src2, the out_valid/out_ready response with result/illegal, and flush.
// Define ALU_MULDIV_EN to build codes 0x12-0x19 (shift-add multiply, restoring divide); otherwise they are illegal.
module alu_iter #(
  parameter int XLEN = 32,
  parameter int SHW = $clog2(XLEN)
) (
  input logic clk,
  input logic rst_n,
  alu_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [SHW-1:0] cnt;
  logic [SHW-1:0] sh;
  logic [XLEN-1:0] a, b, fast_res, res_q;
  logic [5:0] op;
  logic fast_ill, iter, ill_q, accept, last;
  assign a = bus.src1;
  assign b = bus.src2;
  assign op = bus.alu_cntrl;
  assign sh = b[SHW-1:0];
  assign accept = state == IDLE && bus.in_valid && !bus.flush;
  assign last = cnt == SHW'(XLEN - 1);
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.result = res_q;
  assign bus.illegal = ill_q;
`ifdef ALU_MULDIV_EN
  logic sgn, ovf;
  assign sgn = !op[0];
  assign ovf = sgn && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
`endif
  always_comb begin
    fast_res = '0;
    fast_ill = 1'b0;
    iter = 1'b0;
    case (op)
      6'h00: fast_res = a + b;
      6'h01: fast_res = a - b;
      6'h02: fast_res = a << sh;
      6'h03: fast_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      6'h04: fast_res = {{(XLEN-1){1'b0}}, a < b};
      6'h05: fast_res = a ^ b;
      6'h06: fast_res = a >> sh;
      6'h07: fast_res = $signed(a) >>> sh;
      6'h08: fast_res = a | b;
      6'h09: fast_res = a & b;
      6'h11: fast_res = b;
`ifdef ALU_MULDIV_EN
      6'h12, 6'h13, 6'h14, 6'h15: iter = 1'b1;
      6'h16, 6'h17, 6'h18, 6'h19:
        if (b == '0) fast_res = op[3] ? a : '1;
        else if (ovf) fast_res = op[3] ? '0 : a;
        else iter = 1'b1;
`endif
      default: fast_ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // flush overrides every transition, including a same-cycle acceptance
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.in_valid) state_n = iter ? BUSY : DONE;
      BUSY: if (last) state_n = DONE;
      DONE: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.flush) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= state == BUSY && !bus.flush && !last ? cnt + 1'b1 : '0;
`ifdef ALU_MULDIV_EN
  // Both engines run on magnitudes; signs are reapplied on the final BUSY cycle.
  // acc = product high half / partial remainder, lo = multiplier / dividend-then-quotient, opd = multiplicand / divisor.
  logic [XLEN-1:0] acc, lo, opd, acc_n, lo_n, ma, mb, iter_res;
  logic [XLEN:0] mul_sum, r_sh, diff;
  logic [2*XLEN-1:0] prod;
  logic [5:0] op_q;
  logic is_div, div_q, na, nb, neg_q, neg_r;
  assign is_div = op >= 6'h16;
  assign na = a[XLEN-1] && (is_div ? sgn : op == 6'h13 || op == 6'h14);
  assign nb = b[XLEN-1] && (is_div ? sgn : op == 6'h13);
  assign ma = na ? -a : a;
  assign mb = nb ? -b : b;
  assign div_q = op_q >= 6'h16;
  assign mul_sum = {1'b0, acc} + {1'b0, opd & {XLEN{lo[0]}}};
  assign r_sh = {acc, lo[XLEN-1]};
  assign diff = r_sh - {1'b0, opd};
  assign acc_n = div_q ? (diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0]) : mul_sum[XLEN:1];
  assign lo_n = div_q ? {lo[XLEN-2:0], !diff[XLEN]} : {mul_sum[0], lo[XLEN-1:1]};
  assign prod = neg_q ? -{acc_n, lo_n} : {acc_n, lo_n};
  assign iter_res = !div_q ? (op_q == 6'h12 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                  : op_q[3] ? (neg_r ? -acc_n : acc_n) : (neg_q ? -lo_n : lo_n);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      lo <= '0;
      opd <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept && iter) begin
      acc <= '0;
      lo <= is_div ? ma : mb;
      opd <= is_div ? mb : ma;
      op_q <= op;
      neg_q <= na ^ nb;
      neg_r <= na;
    end else if (state == BUSY) begin
      acc <= acc_n;
      lo <= lo_n;
    end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_q <= '0;
      ill_q <= 1'b0;
    end else if (accept) begin
      res_q <= fast_res;
      ill_q <= fast_ill;
    end
`ifdef ALU_MULDIV_EN
    else if (state == BUSY && last && !bus.flush) res_q <= iter_res;
`endif
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: self-checking bench for alu_iter (XLEN=32) against an arithmetic reference model
module tb_alu_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [5:0] fast_ops [11] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h11};
  always #5 clk = ~clk;
  alu_iter_if #(.XLEN(32)) bus ();
  alu_iter #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    logic signed [63:0] sa, sb, p;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    r = '0;
    ill = 1'b0;
    lat = 1;
    case (op)
      6'h00: r = a + b;
      6'h01: r = a - b;
      6'h02: r = a << b[4:0];
      6'h03: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h04: r = (a < b) ? 32'd1 : 32'd0;
      6'h05: r = a ^ b;
      6'h06: r = a >> b[4:0];
      6'h07: r = $signed(a) >>> b[4:0];
      6'h08: r = a | b;
      6'h09: r = a & b;
      6'h11: r = b;
`ifdef ALU_MULDIV_EN
      6'h12: begin p = sa * sb; r = p[31:0]; lat = 33; end
      6'h13: begin p = sa * sb; r = p[63:32]; lat = 33; end
      6'h14: begin p = sa * $signed({32'd0, b}); r = p[63:32]; lat = 33; end
      6'h15: begin u = {32'd0, a} * {32'd0, b}; r = u[63:32]; lat = 33; end
      6'h16:
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
        else begin r = $signed(a) / $signed(b); lat = 33; end
      6'h17:
        if (b == 0) r = 32'hFFFFFFFF;
        else begin r = a / b; lat = 33; end
      6'h18:
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
        else begin r = $signed(a) % $signed(b); lat = 33; end
      6'h19:
        if (b == 0) r = a;
        else begin r = a % b; lat = 33; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction
  // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic ei;
    int el, lat;
    bit rdy_low;
    model(op, a, b, er, ei, el);
    bus.in_valid = 1'b1;
    bus.alu_cntrl = op;
    bus.src1 = a;
    bus.src2 = b;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.src1 = $urandom;
    bus.src2 = $urandom;
    lat = 1;
    rdy_low = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(el));
    check({tag, " in_ready low while busy"}, 32'(rdy_low && !bus.in_ready), 32'd1);
    check({tag, " result"}, bus.result, er);
    check({tag, " illegal"}, 32'(bus.illegal), 32'(ei));
    repeat (hold) begin
      bus.in_valid = 1'b1;
      bus.alu_cntrl = 6'h00;
      bus.src1 = $urandom;
      bus.src2 = $urandom;
      @(negedge clk);
      check({tag, " held result"}, bus.result, er);
      check({tag, " held out_valid/in_ready"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " released"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a, b;
    logic [5:0] op;
    bit seen;
    bus.in_valid = 1'b0;
    bus.alu_cntrl = '0;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("reset outputs", {bus.result[29:0], bus.illegal, bus.out_valid}, 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", 32'(bus.in_ready), 32'd1);
    do_op("sra", 6'h07, 32'h80000000, 32'h24, 0);
    do_op("slt", 6'h03, 32'hFFFFFFFF, 32'h1, 0);
    do_op("sltu", 6'h04, 32'hFFFFFFFF, 32'h1, 0);
    do_op("add wrap", 6'h00, 32'hFFFFFFFF, 32'h2, 0);
    do_op("sub wrap", 6'h01, 32'h0, 32'h1, 0);
    do_op("sll upper ignored", 6'h02, 32'h1, 32'hFFFFFFFF, 0);
    do_op("pass", 6'h11, 32'h12345678, 32'hCAFEF00D, 0);
    do_op("illegal 0a", 6'h0A, 32'h5, 32'h6, 0);
    do_op("illegal 10", 6'h10, 32'h5, 32'h6, 0);
    do_op("illegal 3f", 6'h3F, 32'h5, 32'h6, 0);
    do_op("hold", 6'h00, $urandom, $urandom, 5);
    for (int i = 0; i < 24; i++)
      do_op("random alu", fast_ops[$urandom_range(0, 10)], $urandom, $urandom, $urandom_range(0, 2));
    do_op("mulhu max", 6'h15, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op("div by zero", 6'h16, 32'd7, 32'd0, 0);
    do_op("rem overflow", 6'h18, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op("div overflow", 6'h16, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op("div neg", 6'h16, 32'hFFFFFFF9, 32'd2, 0);
    do_op("rem neg", 6'h18, 32'hFFFFFFF9, 32'd2, 2);
    do_op("mulhsu neg", 6'h14, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    for (int i = 0; i < 12; i++) begin
      op = 6'h12 + 6'($urandom_range(0, 7));
      a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
      do_op("random muldiv", op, a, b, $urandom_range(0, 1));
    end
    bus.in_valid = 1'b1;
    bus.alu_cntrl = 6'h00;
    bus.src1 = 32'd4;
    bus.src2 = 32'd4;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    check("flush same-cycle request", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.src1 = 32'd1;
    bus.src2 = 32'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre-flush done", {29'd0, bus.result[1:0], bus.out_valid}, 32'd7);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush in done", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
`ifdef ALU_MULDIV_EN
    bus.in_valid = 1'b1;
    bus.alu_cntrl = 6'h16;
    bus.src1 = 32'd1000;
    bus.src2 = 32'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush div in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("flush div out_valid never", 32'(seen), 32'd0);
`endif
    bus.in_valid = 1'b1;
`ifdef ALU_MULDIV_EN
    bus.alu_cntrl = 6'h12;
`else
    bus.alu_cntrl = 6'h00;
`endif
    bus.src1 = 32'd3;
    bus.src2 = 32'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {bus.result[29:0], bus.illegal, bus.out_valid}, 32'd0);
    check("async reset in_ready", 32'(bus.in_ready), 32'd1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    seen = 1'b0;
    repeat (40) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abandoned op never completes", 32'(seen), 32'd0);
    do_op("add after reset", 6'h00, 32'd2, 32'd3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width (derived; not overridden).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  in  1  request present.
REQ-006 SHALL have port in_ready  out  1  block accepts a request this cycle.
REQ-007 SHALL have port alu_cntrl  in  6  operation code.
REQ-008 SHALL have port src1, src2  in  XLEN each  operands (immediate forms are presented on src2 by the decoder).
REQ-009 SHALL have port flush  in  1  synchronous abort of any in-flight operation.
REQ-010 SHALL have port out_valid  out  1  result present.
REQ-011 SHALL have port out_ready  in  1  consumer takes result.
REQ-012 SHALL have port result  out  XLEN  registered result.
REQ-013 SHALL have port illegal  out  1  qualifies result; set for unsupported alu_cntrl.

Function
REQ-014 SHALL accept a request when in_valid and in_ready are both high at a rising edge; in_ready SHALL be high only in state IDLE.
REQ-015 SHALL implement states IDLE, BUSY and DONE: IDLE->DONE for single-cycle ops; IDLE->BUSY for iterative ops; BUSY->DONE when the iteration counter reaches XLEN-1; DONE->IDLE when out_ready is high.
REQ-016 SHALL assert out_valid exactly in DONE and SHALL hold result and illegal stable until out_valid and out_ready are both high.
REQ-017 SHALL decode codes 0x00 ADD, 0x01 SUB, 0x02 SLL, 0x03 SLT (signed), 0x04 SLTU (unsigned), 0x05 XOR, 0x06 SRL, 0x07 SRA (sign-filling), 0x08 OR, 0x09 AND, and 0x11 PASS (result=src2), each with latency 1 (out_valid the cycle after acceptance).
REQ-018 SHALL use src2[SHW-1:0] as the shift amount and ignore the upper src2 bits for shifts.
REQ-019 SHALL compute ADD/SUB modulo 2^XLEN without any overflow flag.
REQ-020 SHALL decode codes 0x12 MUL, 0x13 MULH, 0x14 MULHSU, 0x15 MULHU, 0x16 DIV, 0x17 DIVU, 0x18 REM and 0x19 REMU as iterative ops when the multiply/divide feature is compiled in.
REQ-021 SHALL compute multiply as radix-2 shift-add over XLEN BUSY cycles, giving latency XLEN+1, with MUL returning the low XLEN bits and the MULH variants the high XLEN bits of the 2*XLEN signed/mixed/unsigned product.
REQ-022 SHALL compute divide as restoring division over XLEN BUSY cycles, giving latency XLEN+1, with quotient truncated toward zero and remainder taking the sign of the dividend.
REQ-023 SHALL resolve division by zero in a single cycle (IDLE->DONE) with quotient all-ones and remainder equal to src1.
REQ-024 SHALL resolve signed overflow (src1 = -2^(XLEN-1), src2 = -1) in a single cycle with DIV returning src1 and REM returning 0.
REQ-025 SHALL treat any other alu_cntrl value as illegal with latency 1, result 0 and illegal set to 1.
REQ-026 SHALL give flush priority over every other event: flush forces IDLE next cycle, deasserts out_valid and discards both the in-flight operation and any request accepted in the same cycle.
REQ-027 SHALL ignore in_valid while in BUSY or DONE and SHALL NOT capture operands in those states.

Reset
REQ-028 SHALL on rst_n low immediately force the state to IDLE, out_valid to 0, result to 0, illegal to 0 and the iteration counter to 0, regardless of the clock.
REQ-029 SHALL abandon any operation in progress at reset, and SHALL have in_ready high from the first edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro ALU_MULDIV_EN defined, implement REQ-020 to REQ-024.
REQ-031 SHALL, without ALU_MULDIV_EN, treat codes 0x12-0x19 as illegal per REQ-025, never enter BUSY, and contain no multiply/divide datapath.

Verification
REQ-032 SHALL pass: XLEN=32, SRA with src1=0x80000000 and src2=0x24 -> result 0xF8000000 one cycle after acceptance.
REQ-033 SHALL pass: SLT with src1=0xFFFFFFFF, src2=1 -> result 1; SLTU with the same operands -> result 0.
REQ-034 SHALL pass (ALU_MULDIV_EN): MULHU with src1=src2=0xFFFFFFFF -> result 0xFFFFFFFE with out_valid exactly 33 cycles after acceptance and in_ready low throughout.
REQ-035 SHALL pass (ALU_MULDIV_EN): DIV 7/0 -> 0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF -> 0; each with latency 1.
REQ-036 SHALL pass: out_ready held low for 5 cycles in DONE -> result stable and in_ready low throughout; flush asserted in cycle 10 of a DIV -> out_valid never rises and in_ready is high the next cycle.
REQ-037 SHALL pass: rst_n pulsed low mid-BUSY -> outputs take their reset values asynchronously, and a subsequent ADD 2+3 -> result 5.
